// File: rtl/uart_tx_ctrl.sv
// UART transmit controller.
// Sequences start / 8 data bits (LSB first) / optional parity / stop and
// drives the select and data inputs of a downstream 4:1 line mux.
// All outputs come straight from flops, so the mux select only changes on
// bit boundaries and never glitches.
module uart_tx_ctrl #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_tx_start,
   input  logic [7:0] i_tx_data,
   input  logic       i_parity_en,
   input  logic       i_parity_odd,
   output logic       o_sel_1,
   output logic       o_sel_0,
   output logic       o_start_bit,
   output logic       o_data_bit,
   output logic       o_parity_bit,
   output logic       o_stop_bit,
   output logic       o_busy,
   output logic       o_done
);

   localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    data_q, data_d;
   logic          par_en_q, par_en_d;
   logic          par_q, par_d;
   logic [1:0]    sel_q, sel_d;
   logic          data_bit_q, data_bit_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          bit_end;

   // Mux select encoding for each state: 00 start, 01 data, 10 parity, 11 stop/idle.
   function automatic logic [1:0] sel_of(state_t s);
      case (s)
         S_START:  return 2'b00;
         S_DATA:   return 2'b01;
         S_PARITY: return 2'b10;
         default:  return 2'b11;
      endcase
   endfunction

   // State and datapath registers; reset parks the line at stop/idle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_q      <= 1'b0;
         sel_q      <= 2'b11;
         data_bit_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         par_en_q   <= par_en_d;
         par_q      <= par_d;
         sel_q      <= sel_d;
         data_bit_q <= data_bit_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next-state and next-output logic; outputs are derived from the next
   // state so that their flops line up with the state register.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      data_d   = data_q;
      par_en_d = par_en_q;
      par_d    = par_q;
      bit_end  = (cnt_q == CNT_LAST);

      // Bit-period counter runs only inside a frame and wraps each bit.
      if (state_q != S_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (i_tx_start) begin
               state_d  = S_START;
               data_d   = i_tx_data;
               par_en_d = i_parity_en;
               par_d    = (^i_tx_data) ^ i_parity_odd;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (idx_q == 3'd7) begin
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      sel_d      = sel_of(state_d);
      data_bit_d = (state_d == S_DATA) ? data_d[idx_d] : 1'b1;
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_STOP) && (cnt_d == CNT_LAST);
   end

   assign o_sel_1      = sel_q[1];
   assign o_sel_0      = sel_q[0];
   assign o_start_bit  = 1'b0;
   assign o_data_bit   = data_bit_q;
   assign o_parity_bit = par_q;
   assign o_stop_bit   = 1'b1;
   assign o_busy       = busy_q;
   assign o_done       = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: the driver queues expected frames,
// an independent monitor checks every frame cycle against a frame model.
module tb_uart_tx_ctrl;

   localparam int N  = 4;
   localparam int NB = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       a_start = 1'b0;
   logic [7:0] a_data = 8'h00;
   logic       a_pe = 1'b0, a_po = 1'b0;
   logic       a_sel1, a_sel0, a_sb, a_db, a_pb, a_stb, a_busy, a_done;

   logic       b_start = 1'b0;
   logic [7:0] b_data = 8'h00;
   logic       b_pe = 1'b0, b_po = 1'b0;
   logic       b_sel1, b_sel0, b_sb, b_db, b_pb, b_stb, b_busy, b_done;

   uart_tx_ctrl #(.CLKS_PER_BIT(N)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_tx_start(a_start), .i_tx_data(a_data),
      .i_parity_en(a_pe), .i_parity_odd(a_po), .o_sel_1(a_sel1), .o_sel_0(a_sel0),
      .o_start_bit(a_sb), .o_data_bit(a_db), .o_parity_bit(a_pb), .o_stop_bit(a_stb),
      .o_busy(a_busy), .o_done(a_done));

   uart_tx_ctrl #(.CLKS_PER_BIT(NB)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_tx_start(b_start), .i_tx_data(b_data),
      .i_parity_en(b_pe), .i_parity_odd(b_po), .o_sel_1(b_sel1), .o_sel_0(b_sel0),
      .o_start_bit(b_sb), .o_data_bit(b_db), .o_parity_bit(b_pb), .o_stop_bit(b_stb),
      .o_busy(b_busy), .o_done(b_done));

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       po;
   } frame_t;

   frame_t exp_q[$];
   int total = 0;
   int bad = 0;

   // ---------------- reference model (bit-slot view of a frame) ----------------
   function automatic logic exp_par(frame_t f);
      return (^f.d) ^ f.po;
   endfunction

   function automatic int frame_len(frame_t f, int n);
      return (10 + (f.pe ? 1 : 0)) * n;
   endfunction

   function automatic logic [1:0] exp_sel(frame_t f, int n, int k);
      int b;
      b = k / n;
      if (b == 0) return 2'b00;
      if (b <= 8) return 2'b01;
      if (f.pe && b == 9) return 2'b10;
      return 2'b11;
   endfunction

   function automatic logic exp_line(frame_t f, int n, int k);
      int b;
      b = k / n;
      if (b == 0) return 1'b0;
      if (b <= 8) return f.d[b-1];
      if (f.pe && b == 9) return exp_par(f);
      return 1'b1;
   endfunction

   function automatic logic mux_line(logic [1:0] s, logic sb, logic db, logic pb, logic stb);
      case (s)
         2'b00:   return sb;
         2'b01:   return db;
         2'b10:   return pb;
         default: return stb;
      endcase
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard for dut_a ----------------
   frame_t cur;
   int     mk = 0;
   bit     in_frame = 1'b0;
   bit     skip = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame = 1'b0;
         skip     = 1'b0;
      end else begin
         if (!a_busy && !in_frame) begin
            chk("idle_done", a_done, 0);
            chk("idle_sel", {a_sel1, a_sel0}, 2'b11);
         end
         if (a_busy && !in_frame) begin
            in_frame = 1'b1;
            mk = 0;
            if (exp_q.size() == 0) begin
               skip = 1'b1;
               chk("unexpected_frame", 1, 0);
            end else begin
               skip = 1'b0;
               cur = exp_q.pop_front();
            end
         end
         if (in_frame) begin
            if (a_busy) begin
               if (!skip) begin
                  chk("sel", {a_sel1, a_sel0}, exp_sel(cur, N, mk));
                  chk("line", mux_line({a_sel1, a_sel0}, a_sb, a_db, a_pb, a_stb), exp_line(cur, N, mk));
                  chk("parity_bit", a_pb, exp_par(cur));
                  chk("done", a_done, (mk == frame_len(cur, N) - 1) ? 1 : 0);
               end
               mk++;
            end else begin
               if (!skip) chk("frame_len", mk, frame_len(cur, N));
               in_frame = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks (called at a negedge with dut_a idle) --------
   task automatic send(logic [7:0] d, logic pe, logic po, bit disturb);
      frame_t f;
      f.d = d; f.pe = pe; f.po = po;
      a_start = 1'b1; a_data = d; a_pe = pe; a_po = po;
      exp_q.push_back(f);
      @(negedge clk);
      a_start = 1'b0;
      chk("accept_busy", a_busy, 1);
      if (disturb) begin
         repeat (20) begin
            a_data  = 8'($urandom);
            a_pe    = 1'($urandom);
            a_po    = 1'($urandom);
            a_start = 1'($urandom);
            @(negedge clk);
         end
         a_start = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (a_busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", (n < 200) ? 1 : 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // ---------------- main stimulus ----------------
   initial begin
      frame_t f;
      frame_t fb;
      int n, k, errs, dones;

      // reset state
      #12;
      chk("rst_sel", {a_sel1, a_sel0}, 2'b11);
      chk("rst_busy", a_busy, 0);
      chk("rst_done", a_done, 0);
      chk("rst_data_bit", a_db, 1);
      chk("rst_parity_bit", a_pb, 0);
      chk("rst_start_bit", a_sb, 0);
      chk("rst_stop_bit", a_stb, 1);
      chk("rst_b_sel", {b_sel1, b_sel0}, 2'b11);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 0xA5, no parity, 40-cycle frame
      send(8'hA5, 1'b0, 1'b0, 1'b0);
      wait_idle();
      // 0x07 even then odd parity
      send(8'h07, 1'b1, 1'b0, 1'b0);
      wait_idle();
      send(8'h07, 1'b1, 1'b1, 1'b0);
      wait_idle();

      // mid-frame data changes and start toggling
      send(8'h96, 1'b1, 1'b0, 1'b1);
      wait_idle();

      // held start across two frames, second byte changed mid-frame
      a_start = 1'b1; a_data = 8'h3C; a_pe = 1'b1; a_po = 1'b0;
      f.d = 8'h3C; f.pe = 1'b1; f.po = 1'b0;
      exp_q.push_back(f);
      @(negedge clk);
      chk("held_accept", a_busy, 1);
      repeat (10) @(negedge clk);
      a_data = 8'hC3; a_pe = 1'b0; a_po = 1'b1;
      f.d = 8'hC3; f.pe = 1'b0; f.po = 1'b1;
      exp_q.push_back(f);
      n = 0;
      while (!a_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("held_done_seen", a_done, 1);
      @(negedge clk);
      chk("gap_busy", a_busy, 0);
      chk("gap_sel", {a_sel1, a_sel0}, 2'b11);
      @(negedge clk);
      chk("second_accept", a_busy, 1);
      a_start = 1'b0;
      wait_idle();

      // reset during data bit 3
      send(8'h5A, 1'b0, 1'b0, 1'b0);
      repeat (17) @(negedge clk);
      chk("pre_abort_sel", {a_sel1, a_sel0}, 2'b01);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_sel", {a_sel1, a_sel0}, 2'b11);
      chk("abort_busy", a_busy, 0);
      chk("abort_done", a_done, 0);
      @(negedge clk);
      chk("abort_sel_edge", {a_sel1, a_sel0}, 2'b11);
      chk("abort_done_edge", a_done, 0);
      // start held through reset: first acceptance only after release
      a_start = 1'b1; a_data = 8'h81; a_pe = 1'b1; a_po = 1'b1;
      f.d = 8'h81; f.pe = 1'b1; f.po = 1'b1;
      exp_q.push_back(f);
      @(negedge clk);
      chk("reset_hold_busy", a_busy, 0);
      rst_n = 1'b1;
      #1;
      chk("release_no_accept", a_busy, 0);
      @(negedge clk);
      chk("post_reset_accept", a_busy, 1);
      a_start = 1'b0;
      wait_idle();

      // minimum bit period: 0xFF odd parity on dut_b
      b_start = 1'b1; b_data = 8'hFF; b_pe = 1'b1; b_po = 1'b1;
      fb.d = 8'hFF; fb.pe = 1'b1; fb.po = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      k = 0; errs = 0; dones = 0;
      while (b_busy && k < 100) begin
         if ({b_sel1, b_sel0} !== exp_sel(fb, NB, k)) errs++;
         if (mux_line({b_sel1, b_sel0}, b_sb, b_db, b_pb, b_stb) !== exp_line(fb, NB, k)) errs++;
         if (b_done !== ((k == frame_len(fb, NB) - 1) ? 1'b1 : 1'b0)) errs++;
         if (b_done === 1'b1) dones++;
         @(negedge clk);
         k++;
      end
      chk("b_frame_len", k, 22);
      chk("b_bit_errors", errs, 0);
      chk("b_done_count", dones, 1);
      chk("b_parity_bit", b_pb, 1);

      // randomized frames, some with mid-frame disturbance
      repeat (20) begin
         send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
         wait_idle();
      end

      @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_tx_start, input, 1, frame request, level-sampled.
REQ-005 The block SHALL have port i_tx_data, input, 8, byte to transmit.
REQ-006 The block SHALL have port i_parity_en, input, 1, 1 = insert parity bit.
REQ-007 The block SHALL have port i_parity_odd, input, 1, 1 = odd parity, 0 = even.
REQ-008 The block SHALL have ports o_sel_1 and o_sel_0, output, 1 each, downstream 4:1 mux select (00 start, 01 data, 10 parity, 11 stop/idle).
REQ-009 The block SHALL have ports o_start_bit, o_data_bit, o_parity_bit and o_stop_bit, output, 1 each, mux data inputs 0..3.
REQ-010 The block SHALL have port o_busy, output, 1, frame in progress.
REQ-011 The block SHALL have port o_done, output, 1, one-cycle end-of-frame pulse.

Function
REQ-012 The block SHALL drive o_start_bit constant 0 and o_stop_bit constant 1.
REQ-013 The block SHALL implement states IDLE, START, DATA, PARITY and STOP, with select 11, 00, 01, 10 and 11 respectively.
REQ-014 In IDLE, when i_tx_start is 1, the block SHALL latch i_tx_data, i_parity_en and i_parity_odd, and enter START on the next edge with the bit counter cleared.
REQ-015 The block SHALL ignore i_tx_start in every state other than IDLE, and SHALL ignore changes to i_tx_data and the parity inputs after latching.
REQ-016 The block SHALL hold each of START, PARITY and STOP for exactly CLKS_PER_BIT cycles, and each data bit for exactly CLKS_PER_BIT cycles.
REQ-017 In DATA, the block SHALL present latched bits LSB first on o_data_bit, bit 0..7, for a total of 8*CLKS_PER_BIT cycles, then move to PARITY if parity was latched enabled, else to STOP.
REQ-018 The block SHALL set o_parity_bit to the XOR of the latched byte for even parity and its inverse for odd parity, stable from acceptance to frame end.
REQ-019 At the end of STOP, the block SHALL return to IDLE.
REQ-020 Frame length SHALL be (10 + P)*CLKS_PER_BIT cycles, where P = latched parity enable.
REQ-021 The block SHALL assert o_busy in the cycle after acceptance and deassert it in the first IDLE cycle.
REQ-022 The block SHALL pulse o_done high for exactly the last cycle of STOP.
REQ-023 If i_tx_start is held high, the block SHALL accept the next frame on the first IDLE cycle, giving exactly one idle cycle (select 11) between frames.
REQ-024 The bit-period counter SHALL wrap to 0 at CLKS_PER_BIT-1 and SHALL NOT free-run in IDLE, where it is held at 0.
REQ-025 The select outputs SHALL be registered and glitch-free, changing only on bit boundaries.

Reset
REQ-026 While i_rst_n is 0, the block SHALL be in IDLE with o_sel_1/o_sel_0 = 11, o_busy = 0, o_done = 0, o_data_bit = 1, o_parity_bit = 0, counters = 0 and the data latch = 0.
REQ-027 Reset assertion mid-frame SHALL abort the frame immediately and asynchronously, force the line to 1 (stop/idle select), and not pulse o_done.
REQ-028 After i_rst_n deasserts, the first acceptance SHALL occur no earlier than the first rising edge with i_rst_n = 1.

Verification
REQ-029 With CLKS_PER_BIT=4, no parity, and data 0xA5, the mux output SHALL be 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total), and o_done SHALL pulse at cycle 40.
REQ-030 With even parity on 0x07, the parity bit SHALL be 1; with odd parity on 0x07, the parity bit SHALL be 0; frame length SHALL be 44 cycles at CLKS_PER_BIT=4.
REQ-031 With i_tx_start held high across two frames, there SHALL be exactly 1 idle cycle between the frames, and the second byte SHALL be latched at that cycle.
REQ-032 Changing i_tx_data and toggling i_tx_start mid-frame SHALL leave the transmitted bits unchanged and produce no extra frame.
REQ-033 Asserting i_rst_n=0 during data bit 3 SHALL give select 11, o_busy=0 and no o_done, with the same result without a clock edge.
REQ-034 With CLKS_PER_BIT=2 (minimum), 0xFF with odd parity SHALL give a frame of 22 cycles with parity bit 1.
